// File: rtl/gf_pkg.sv
// Shared definitions for the digit-serial GF(2^k) reduce / multiply-reduce unit.
package gf_pkg;

  // Per-transaction operation select
  localparam logic GF_MODE_REDUCE = 1'b0;
  localparam logic GF_MODE_MULRED = 1'b1;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } gf_state_e;

  // A field degree is usable when it lies in [2, max_k]
  function automatic logic grade_ok(input int k, input int max_k);
    return (k >= 2) && (k <= max_k);
  endfunction

endpackage

// File: rtl/gf_red_step.sv
// One coefficient step of MSB-first polynomial reduction / multiply-reduction.
// REDUCE : acc' = (acc<<1 | bit) mod p
// MULRED : acc' = ((acc<<1) mod p) ^ (bit ? a : 0)
// poly_i carries p[k-1:0] plus bit k set (when k < DW), so a single xor both
// folds the overflow back in and clears the overflow bit. For k == DW the
// overflow bit falls outside the returned slice, which has the same effect.
module gf_red_step
  import gf_pkg::*;
#(
  parameter int DW = 10,
  parameter int GW = 5
) (
  input  logic [DW-1:0] acc_i,
  input  logic          bit_i,
  input  logic [DW-1:0] poly_i,
  input  logic [GW-1:0] grade_i,
  input  logic          mode_i,
  input  logic [DW-1:0] a_i,
  output logic [DW-1:0] acc_o
);

  logic [DW:0]   shifted;
  logic          top_set;
  logic [DW-1:0] reduced;

  // Shift in the next coefficient, reduce on overflow at bit k, then add a
  always_comb begin
    shifted = {acc_i, (mode_i == GF_MODE_REDUCE) ? bit_i : 1'b0};
    top_set = 1'b0;
    for (int j = 0; j <= DW; j++) begin
      if (int'(grade_i) == j) top_set = shifted[j];
    end
    reduced = top_set ? (shifted[DW-1:0] ^ poly_i) : shifted[DW-1:0];
    acc_o   = reduced;
    if ((mode_i == GF_MODE_MULRED) && bit_i) acc_o = reduced ^ a_i;
  end

endmodule

// File: rtl/gf_mulred_seq.sv
// Digit-serial GF(2^k) unit: REDUCE (2k-bit operand mod p) or MULREDUCE
// (a*b mod p), DIGIT coefficient bits per cycle, valid/ready on both sides.
// The operand is left-aligned in a shift register on accept so the next
// coefficient to consume is always at the top; bits above the used range
// are shifted out during that alignment.
module gf_mulred_seq
  import gf_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int DIGIT      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        mode,
  input  logic [$clog2(DATA_WIDTH):0] polyn_grade,
  input  logic [DATA_WIDTH:0]         polyn_red_in,
  input  logic [2*DATA_WIDTH-1:0]     reduc_in,
  input  logic [DATA_WIDTH-1:0]       a_in,
  input  logic [DATA_WIDTH-1:0]       b_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out,
  output logic                        err
);

  localparam int GW = $clog2(DATA_WIDTH) + 1;
  localparam int OW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(OW + 1);

  gf_state_e             state_q, state_d;
  logic                  mode_q, mode_d;
  logic [GW-1:0]         k_q, k_d;
  logic [DATA_WIDTH-1:0] p_q, p_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  err_q, err_d;
  logic [OW-1:0]         opnd_q, opnd_d;
  logic [CW-1:0]         rem_q, rem_d;

  logic [DATA_WIDTH-1:0] acc_chain [DIGIT+1];
  logic [DATA_WIDTH-1:0] step_out  [DIGIT];
  logic [DIGIT-1:0]      stage_en;

  // Bit k of p is implied to be 1, so the top input bit never carries information
  logic                  unused_p_top;
  assign unused_p_top = polyn_red_in[DATA_WIDTH];

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out       = out_q;
  assign err       = err_q;

  assign acc_chain[0] = acc_q;

  // DIGIT chained steps; a stage past the remaining bit count passes acc through
  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_stage
      assign stage_en[gi] = (gi < int'(rem_q));

      gf_red_step #(
        .DW (DATA_WIDTH),
        .GW (GW)
      ) u_step (
        .acc_i   (acc_chain[gi]),
        .bit_i   (opnd_q[OW-1-gi]),
        .poly_i  (p_q),
        .grade_i (k_q),
        .mode_i  (mode_q),
        .a_i     (a_q),
        .acc_o   (step_out[gi])
      );

      assign acc_chain[gi+1] = stage_en[gi] ? step_out[gi] : acc_chain[gi];
    end
  endgenerate

  // Controller: accept and align operands, run the digit chain, hold the result
  always_comb begin
    int kin;
    state_d = state_q;
    mode_d  = mode_q;
    k_d     = k_q;
    p_d     = p_q;
    a_d     = a_q;
    acc_d   = acc_q;
    out_d   = out_q;
    err_d   = err_q;
    opnd_d  = opnd_q;
    rem_d   = rem_q;
    kin     = int'(polyn_grade);

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mode_d = mode;
          k_d    = polyn_grade;
          acc_d  = '0;
          if (grade_ok(kin, DATA_WIDTH)) begin
            for (int j = 0; j < DATA_WIDTH; j++) begin
              p_d[j] = (j < kin) ? polyn_red_in[j] : (j == kin);
              a_d[j] = a_in[j] & (j < kin);
            end
            if (mode == GF_MODE_MULRED) begin
              opnd_d = {b_in, {DATA_WIDTH{1'b0}}} << (DATA_WIDTH - kin);
              rem_d  = CW'(kin);
            end else begin
              opnd_d = reduc_in << (OW - 2 * kin);
              rem_d  = CW'(2 * kin);
            end
            state_d = ST_RUN;
          end else begin
            out_d   = '0;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        acc_d  = acc_chain[DIGIT];
        opnd_d = opnd_q << DIGIT;
        if (int'(rem_q) <= DIGIT) begin
          rem_d   = '0;
          out_d   = acc_chain[DIGIT];
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          rem_d = rem_q - CW'(DIGIT);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      k_q     <= '0;
      p_q     <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      opnd_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      k_q     <= k_d;
      p_q     <= p_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      err_q   <= err_d;
      opnd_q  <= opnd_d;
      rem_q   <= rem_d;
    end
  end

endmodule
